// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture
// Description : ADC front-end for the ice40 scope. Generates the ADC clock from
//               a runtime half-period divider and captures one raw sample on
//               each falling ADC clock edge. Raw samples are decimated by 2^k,
//               either by keeping the last sample of each group or by averaging
//               it. The decimated samples then pass through an armable
//               level-crossing trigger that has a programmable capture length.
//
//               Optional feature macro: ADC_CAPTURE_AVG_EN
//                 defined   -> iAvg port and accumulator are built.
//                              iAvg=1 averages, iAvg=0 picks.
//                 undefined -> pick-only decimation, no iAvg port.
//
// Ports       : iClk          system clock
//               iRst          synchronous active-high reset
//               iEnable       front-end enable (0 = idle, FSM to IDLE)
//               iHalfPeriod   ADC clock half period minus 1 (iClk cycles)
//               iDecimLog2    decimation exponent k (factor 2^k)
//               iTrigLevel    trigger threshold, unsigned
//               iTrigRising   1 = rising crossing, 0 = falling crossing
//               iCaptureLen   samples per capture, 0 = continuous
//               iArm          single-cycle arm request
//               iADC_Data     ADC parallel data
//               iAvg          (macro only) 1 = average, 0 = pick
//               oADC_CLK      ADC clock
//               oADC_nOE      ADC output enable, active low
//               oADC_Data     captured/decimated sample
//               oData_Valid   one-cycle qualifier for oADC_Data
//               oTrigged      high from trigger sample until DONE/IDLE
//               oDone         high in DONE
//
// Revision    : 1.0  initial release
// ============================================================================
module adc_capture #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 8,
    parameter int DEC_LOG_W = 3,
    parameter int LEN_W     = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEnable,
    input  logic [DIV_W-1:0]     iHalfPeriod,
    input  logic [DEC_LOG_W-1:0] iDecimLog2,
    input  logic [DATA_W-1:0]    iTrigLevel,
    input  logic                 iTrigRising,
    input  logic [LEN_W-1:0]     iCaptureLen,
    input  logic                 iArm,
    input  logic [DATA_W-1:0]    iADC_Data,
`ifdef ADC_CAPTURE_AVG_EN
    input  logic                 iAvg,
`endif
    output logic                 oADC_CLK,
    output logic                 oADC_nOE,
    output logic [DATA_W-1:0]    oADC_Data,
    output logic                 oData_Valid,
    output logic                 oTrigged,
    output logic                 oDone
);

    // Group counter must reach 2^k - 1 for the largest k.
    localparam int c_DEC_CNT_W = (1 << DEC_LOG_W) - 1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    // ------------------------------------------------------------------------
    // ADC clock divider
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] r_divCnt;
    logic             r_adcClk;
    logic             r_nOE;
    logic             w_divWrap;
    logic             w_clkFall;

    // ">=" rather than "==" so that shrinking H mid-run wraps at once
    // instead of counting through the whole DIV_W range.
    assign w_divWrap = (r_divCnt >= iHalfPeriod);
    assign w_clkFall = iEnable && r_adcClk && w_divWrap;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_divCnt <= '0;
            r_adcClk <= 1'b0;
            r_nOE    <= 1'b1;
        end else begin
            r_nOE <= ~iEnable;
            if (!iEnable) begin
                r_divCnt <= '0;
                r_adcClk <= 1'b0;
            end else if (w_divWrap) begin
                r_divCnt <= '0;
                r_adcClk <= ~r_adcClk;
            end else begin
                r_divCnt <= r_divCnt + DIV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Raw sample register, loaded on the edge where the ADC clock falls
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_raw;
    logic              r_rawValid;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_raw      <= '0;
            r_rawValid <= 1'b0;
        end else begin
            r_rawValid <= w_clkFall;
            if (w_clkFall) begin
                r_raw <= iADC_Data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Decimation group tracking
    // ------------------------------------------------------------------------
    logic [c_DEC_CNT_W-1:0] r_decCnt;
    logic [c_DEC_CNT_W-1:0] w_groupMask;
    logic                   w_groupEnd;
    logic                   w_pickValid;

    assign w_groupMask = ~({c_DEC_CNT_W{1'b1}} << iDecimLog2);
    // ">=" keeps the counter bounded if k is lowered mid-group.
    assign w_groupEnd  = (r_decCnt >= w_groupMask);
    assign w_pickValid = r_rawValid && w_groupEnd;

    always_ff @(posedge iClk) begin
        if (iRst || !iEnable) begin
            r_decCnt <= '0;
        end else if (r_rawValid) begin
            r_decCnt <= w_groupEnd ? '0 : r_decCnt + c_DEC_CNT_W'(1);
        end
    end

    logic              w_decValid;
    logic [DATA_W-1:0] w_decData;

`ifdef ADC_CAPTURE_AVG_EN
    localparam int c_ACC_W = DATA_W + c_DEC_CNT_W;

    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] w_sum;
    logic [DATA_W-1:0]  w_avgData;
    logic [DATA_W-1:0]  r_avgData;
    logic               r_avgValid;

    assign w_sum     = r_acc + c_ACC_W'(r_raw);
    // Truncating average: plain shift, no rounding term.
    assign w_avgData = DATA_W'(w_sum >> iDecimLog2);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_acc      <= '0;
            r_avgData  <= '0;
            r_avgValid <= 1'b0;
        end else if (!iEnable) begin
            r_acc      <= '0;
            r_avgValid <= 1'b0;
        end else begin
            r_avgValid <= w_pickValid;
            if (r_rawValid) begin
                r_acc <= w_groupEnd ? '0 : w_sum;
                if (w_groupEnd) begin
                    r_avgData <= w_avgData;
                end
            end
        end
    end

    assign w_decValid = iAvg ? r_avgValid : w_pickValid;
    assign w_decData  = iAvg ? r_avgData  : r_raw;
`else
    assign w_decValid = w_pickValid;
    assign w_decData  = r_raw;
`endif

    // ------------------------------------------------------------------------
    // Trigger / capture FSM
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_stateNext;
    logic [DATA_W-1:0] r_level;
    logic              r_rising;
    logic [DATA_W-1:0] r_prev;
    logic              r_prevValid;
    logic [LEN_W-1:0]  r_lenCnt;
    logic [LEN_W-1:0]  w_lenNext;
    logic              w_hit;
    logic              w_fire;
    logic              w_lastSample;

    assign w_hit = r_rising ? ((r_prev <  r_level) && (w_decData >= r_level))
                            : ((r_prev >= r_level) && (w_decData <  r_level));

    // The first sample after arming only seeds r_prev.
    assign w_fire = (r_state == c_ST_ARMED) && w_decValid && r_prevValid && w_hit;

    // Count of samples emitted including the one being processed now.
    assign w_lenNext    = w_fire ? LEN_W'(1) : r_lenCnt + LEN_W'(1);
    assign w_lastSample = (iCaptureLen != '0) && (w_lenNext == iCaptureLen);

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        w_stateNext = r_state;
        if (!iEnable) begin
            w_stateNext = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (iArm) w_stateNext = c_ST_ARMED;
                end
                c_ST_ARMED: begin
                    if (w_fire) w_stateNext = w_lastSample ? c_ST_DONE : c_ST_CAPTURE;
                end
                c_ST_CAPTURE: begin
                    if (w_decValid && w_lastSample) w_stateNext = c_ST_DONE;
                end
                c_ST_DONE: begin
                    if (iArm) w_stateNext = c_ST_ARMED;
                end
                default: w_stateNext = c_ST_IDLE;
            endcase
        end
    end

    // Output logic
    logic w_emit;
    logic w_trigNext;
    logic w_doneNext;
    logic w_armLatch;

    always_comb begin
        w_emit     = iEnable && w_decValid && (w_fire || (r_state == c_ST_CAPTURE));
        w_trigNext = iEnable && (w_fire || (r_state == c_ST_CAPTURE));
        // Registered from the state so oDone lands one cycle after the
        // final valid, and drops as soon as a re-arm or disable is taken.
        w_doneNext = (r_state == c_ST_DONE) && (w_stateNext == c_ST_DONE);
        w_armLatch = iEnable && iArm &&
                     ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    end

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_trigged;
    logic              r_done;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_level     <= '0;
            r_rising    <= 1'b0;
            r_prev      <= '0;
            r_prevValid <= 1'b0;
            r_lenCnt    <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_trigged   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_armLatch) begin
                r_level     <= iTrigLevel;
                r_rising    <= iTrigRising;
                r_prevValid <= 1'b0;
            end else if ((r_state == c_ST_ARMED) && w_decValid) begin
                r_prev      <= w_decData;
                r_prevValid <= 1'b1;
            end

            if (w_fire || ((r_state == c_ST_CAPTURE) && w_decValid)) begin
                r_lenCnt <= w_lenNext;
            end

            r_valid <= w_emit;
            if (w_emit) begin
                r_data <= w_decData;
            end
            r_trigged <= w_trigNext;
            r_done    <= w_doneNext;
        end
    end

    assign oADC_CLK    = r_adcClk;
    assign oADC_nOE    = r_nOE;
    assign oADC_Data   = r_data;
    assign oData_Valid = r_valid;
    assign oTrigged    = r_trigged;
    assign oDone       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture
// Description : Directed self-checking bench for adc_capture. Drives the ADC
//               data bus once per falling ADC clock edge and checks divider
//               period, sample latency, pick decimation, rising and falling
//               triggers, capture length, re-arm and abort. The averaging
//               case is included when ADC_CAPTURE_AVG_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adc_capture;

    logic        iClk;
    logic        iRst;
    logic        iEnable;
    logic [7:0]  iHalfPeriod;
    logic [2:0]  iDecimLog2;
    logic [7:0]  iTrigLevel;
    logic        iTrigRising;
    logic [15:0] iCaptureLen;
    logic        iArm;
    logic [7:0]  iADC_Data;
`ifdef ADC_CAPTURE_AVG_EN
    logic        iAvg;
`endif
    logic        oADC_CLK;
    logic        oADC_nOE;
    logic [7:0]  oADC_Data;
    logic        oData_Valid;
    logic        oTrigged;
    logic        oDone;

    adc_capture dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iEnable     (iEnable),
        .iHalfPeriod (iHalfPeriod),
        .iDecimLog2  (iDecimLog2),
        .iTrigLevel  (iTrigLevel),
        .iTrigRising (iTrigRising),
        .iCaptureLen (iCaptureLen),
        .iArm        (iArm),
        .iADC_Data   (iADC_Data),
`ifdef ADC_CAPTURE_AVG_EN
        .iAvg        (iAvg),
`endif
        .oADC_CLK    (oADC_CLK),
        .oADC_nOE    (oADC_nOE),
        .oADC_Data   (oADC_Data),
        .oData_Valid (oData_Valid),
        .oTrigged    (oTrigged),
        .oDone       (oDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int   cyc = 0;
    logic clkPrev = 1'b0;
    always @(posedge iClk) begin
        cyc     <= cyc + 1;
        clkPrev <= oADC_CLK;
    end

    // Output recorder: every valid sample with its cycle stamp, plus rise
    // times of oTrigged and oDone.
    logic [7:0] valData[$];
    int         valCyc[$];
    int         trigRise[$];
    int         doneRise[$];
    logic       trigLast = 1'b0;
    logic       doneLast = 1'b0;

    always @(negedge iClk) begin
        if (oData_Valid === 1'b1) begin
            valData.push_back(oADC_Data);
            valCyc.push_back(cyc);
        end
        if (oTrigged === 1'b1 && trigLast !== 1'b1) trigRise.push_back(cyc);
        if (oDone === 1'b1 && doneLast !== 1'b1) doneRise.push_back(cyc);
        trigLast = oTrigged;
        doneLast = oDone;
    end

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Waits for the next falling ADC clock edge (seen at the following
    // negedge), returns its cycle stamp, then presents the next data word.
    task automatic nextFall(input logic [7:0] nxt, output int fallCyc);
        int n;
        n = 0;
        @(negedge iClk);
        while (!(clkPrev === 1'b1 && oADC_CLK === 1'b0) && n < 200) begin
            @(negedge iClk);
            n++;
        end
        if (n >= 200) check("fall_timeout", 32'(n), 0);
        fallCyc   = cyc;
        iADC_Data = nxt;
    endtask

    function automatic int lastOf(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fc;
        int fcPrev;
        int fcTrig;
        int base;
        int n;
        logic [7:0] tbl3 [6];
        tbl3 = '{8'h70, 8'h7F, 8'h80, 8'h90, 8'hA0, 8'h50};

        iRst        = 1'b1;
        iEnable     = 1'b0;
        iHalfPeriod = 8'd4;
        iDecimLog2  = 3'd0;
        iTrigLevel  = 8'd0;
        iTrigRising = 1'b1;
        iCaptureLen = 16'd0;
        iArm        = 1'b0;
        iADC_Data   = 8'd0;
`ifdef ADC_CAPTURE_AVG_EN
        iAvg        = 1'b0;
`endif
        fcPrev = 0;
        fcTrig = 0;

        // ---------------- Reset state ----------------
        repeat (3) @(negedge iClk);
        check("rst_clk",   32'(oADC_CLK),    0);
        check("rst_noe",   32'(oADC_nOE),    1);
        check("rst_data",  32'(oADC_Data),   0);
        check("rst_valid", 32'(oData_Valid), 0);
        check("rst_trig",  32'(oTrigged),    0);
        check("rst_done",  32'(oDone),       0);

        // ---------------- Divider, H=4, continuous capture ----------------
        iRst    = 1'b0;
        iEnable = 1'b1;
        @(negedge iClk);
        check("noe_on", 32'(oADC_nOE), 0);
        iArm        = 1'b1;
        iTrigLevel  = 8'd1;
        iTrigRising = 1'b1;
        iCaptureLen = 16'd0;
        @(negedge iClk);
        iArm = 1'b0;
        base = valData.size();

        for (int i = 0; i < 5; i++) begin
            nextFall(8'(i + 1), fc);
            if (i == 2) check("h4_period", 32'(fc - fcPrev), 10);
            fcPrev = fc;
            @(negedge iClk);
            if (i == 0) begin
                check("h4_seed_novalid", 32'(oData_Valid), 0);
            end else begin
                check("h4_valid_e1", 32'(oData_Valid), 1);
                check("h4_data", 32'(oADC_Data), 32'(i));
            end
            if (i == 1) begin
                check("h4_trig", 32'(oTrigged), 1);
                fcTrig = cyc;
            end
        end
        @(negedge iClk);
        check("h4_valid_one_cycle", 32'(oData_Valid), 0);
        check("h4_trig_rise", 32'(lastOf(trigRise)), 32'(fcTrig));

        // Abort continuous capture while the ADC clock is high.
        n = 0;
        while (oADC_CLK !== 1'b1 && n < 20) begin
            @(negedge iClk);
            n++;
        end
        iEnable = 1'b0;
        @(negedge iClk);
        check("abort_trig",  32'(oTrigged),    0);
        check("abort_clk",   32'(oADC_CLK),    0);
        check("abort_noe",   32'(oADC_nOE),    1);
        check("abort_valid", 32'(oData_Valid), 0);
        repeat (3) @(negedge iClk);
        check("abort_no_output", 32'(valData.size() - base), 4);

        // ---------------- Pick decimation, H=1, k=2 ----------------
        iHalfPeriod = 8'd1;
        iDecimLog2  = 3'd2;
        iADC_Data   = 8'd0;
        @(negedge iClk);
        base        = valData.size();
        iEnable     = 1'b1;
        iArm        = 1'b1;
        iTrigLevel  = 8'd4;
        iTrigRising = 1'b1;
        iCaptureLen = 16'd3;
        @(negedge iClk);
        iArm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            nextFall(8'(i + 1), fc);
            if (i == 7) fcTrig = fc;
        end
        repeat (2) @(negedge iClk);
        check("dec_count", 32'(valData.size() - base), 3);
        check("dec_d0", 32'(valData[base]),     7);
        check("dec_d1", 32'(valData[base + 1]), 11);
        check("dec_d2", 32'(valData[base + 2]), 15);
        check("dec_lat", 32'(valCyc[base]), 32'(fcTrig + 1));
        check("dec_gap", 32'(valCyc[base + 1] - valCyc[base]), 16);
        check("dec_done_rise", 32'(lastOf(doneRise)), 32'(valCyc[base + 2] + 1));
        check("dec_done", 32'(oDone), 1);
        check("dec_trig_low", 32'(oTrigged), 0);

        // ---------------- Rising trigger, level 0x80, len 3 ----------------
        iEnable = 1'b0;
        @(negedge iClk);
        iDecimLog2  = 3'd0;
        iADC_Data   = tbl3[0];
        base        = valData.size();
        iEnable     = 1'b1;
        iArm        = 1'b1;
        iTrigLevel  = 8'h80;
        iTrigRising = 1'b1;
        iCaptureLen = 16'd3;
        @(negedge iClk);
        iArm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nextFall((i < 5) ? tbl3[i + 1] : 8'h50, fc);
            if (i == 2) fcTrig = fc;
        end
        repeat (2) @(negedge iClk);
        check("rise_count", 32'(valData.size() - base), 3);
        check("rise_d0", 32'(valData[base]),     'h80);
        check("rise_d1", 32'(valData[base + 1]), 'h90);
        check("rise_d2", 32'(valData[base + 2]), 'hA0);
        check("rise_lat", 32'(valCyc[base]), 32'(fcTrig + 1));
        check("rise_trig_with_valid", 32'(lastOf(trigRise)), 32'(valCyc[base]));
        check("rise_done_rise", 32'(lastOf(doneRise)), 32'(valCyc[base + 2] + 1));
        check("rise_trig_low", 32'(oTrigged), 0);

        // ---------------- Falling trigger via re-arm from DONE ----------------
        nextFall(8'h40, fc);
        iArm        = 1'b1;
        iTrigLevel  = 8'h80;
        iTrigRising = 1'b0;
        iCaptureLen = 16'd2;
        @(negedge iClk);
        iArm = 1'b0;
        check("rearm_done_low", 32'(oDone), 0);
        base = valData.size();
        nextFall(8'h90, fc);
        nextFall(8'h7F, fc);
        nextFall(8'h60, fc);
        fcTrig = fc;
        nextFall(8'h20, fc);
        nextFall(8'h20, fc);
        repeat (2) @(negedge iClk);
        check("fall_count", 32'(valData.size() - base), 2);
        check("fall_d0", 32'(valData[base]),     'h7F);
        check("fall_d1", 32'(valData[base + 1]), 'h60);
        check("fall_lat", 32'(valCyc[base]), 32'(fcTrig + 1));
        check("fall_done", 32'(oDone), 1);

`ifdef ADC_CAPTURE_AVG_EN
        // ---------------- Averaging, k=2 ----------------
        begin
            logic [7:0] tblA [9];
            tblA = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd11, 8'd12, 8'd14, 8'd0};
            iEnable = 1'b0;
            @(negedge iClk);
            iAvg        = 1'b1;
            iDecimLog2  = 3'd2;
            iADC_Data   = tblA[0];
            base        = valData.size();
            iEnable     = 1'b1;
            iArm        = 1'b1;
            iTrigLevel  = 8'd11;
            iTrigRising = 1'b1;
            iCaptureLen = 16'd1;
            @(negedge iClk);
            iArm = 1'b0;
            for (int i = 0; i < 8; i++) begin
                nextFall(tblA[i + 1], fc);
                if (i == 7) fcTrig = fc;
            end
            repeat (4) @(negedge iClk);
            check("avg_count", 32'(valData.size() - base), 1);
            check("avg_data", 32'(valData[base]), 11);
            check("avg_lat", 32'(valCyc[base]), 32'(fcTrig + 2));
            check("avg_done_rise", 32'(lastOf(doneRise)), 32'(valCyc[base] + 1));
            iAvg = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
